// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: round-robin arbiter, NUM_PORTS requesters onto one memory port |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             port_read,
    input  logic [NUM_PORTS-1:0]             port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_byte_enable,
    output logic [NUM_PORTS-1:0]             port_resp,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [MASK_WIDTH-1:0]            mem_byte_enable,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;

    logic [0:0]            state_q,      state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      grant_q,      grant_d;
    logic                  op_read_q,    op_read_d;
    logic                  op_write_q,   op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [MASK_WIDTH-1:0] mask_q,       mask_d;

    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_win_found;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_sel_read;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [MASK_WIDTH-1:0] w_sel_mask;
    logic                  w_resp_fire;
    int                    w_cand;

    assign w_req = port_read | port_write;

    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            state_q      <= C_ST_IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            op_read_q    <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_read_q    <= op_read_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
        end
    end

    always_comb begin : p_next_state
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_read_d    = op_read_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        w_win_found  = 1'b0;
        w_win_idx    = '0;
        w_sel_read   = 1'b0;
        w_sel_write  = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_mask   = '0;
        w_cand       = 0;

        // Rotating search: the port after the last winner is looked at first.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = (int'(last_grant_q) + k) % NUM_PORTS;
            if (!w_win_found && w_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(w_cand);
                w_sel_read  = port_read[w_cand];
                w_sel_write = port_write[w_cand];
                w_sel_addr  = port_address[w_cand*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = port_wdata[w_cand*DATA_WIDTH +: DATA_WIDTH];
                w_sel_mask  = port_byte_enable[w_cand*MASK_WIDTH +: MASK_WIDTH];
            end
        end

        case (state_q)
            C_ST_IDLE: begin
                if (w_win_found) begin
                    state_d      = C_ST_BUSY;
                    last_grant_d = w_win_idx;
                    grant_d      = w_win_idx;
                    // Read wins when both op bits are set.
                    op_read_d    = w_sel_read;
                    op_write_d   = w_sel_write & ~w_sel_read;
                    addr_d       = w_sel_addr;
                    wdata_d      = w_sel_wdata;
                    mask_d       = w_sel_mask;
                end
            end
            C_ST_BUSY: begin
                if (mem_resp) begin
                    state_d    = C_ST_IDLE;
                    op_read_d  = 1'b0;
                    op_write_d = 1'b0;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        // A reset in the completion cycle suppresses the response.
        w_resp_fire     = (state_q == C_ST_BUSY) && mem_resp && !rst;
        port_resp       = w_resp_fire ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q) : '0;
        port_rdata      = w_resp_fire ? mem_rdata : '0;
        mem_read        = op_read_q;
        mem_write       = op_write_q;
        mem_address     = addr_q;
        mem_wdata       = wdata_q;
        mem_byte_enable = mask_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: randomized bench with transaction-level reference model     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = DW / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      port_read, port_write;
    logic [NP*AW-1:0]   port_address;
    logic [NP*DW-1:0]   port_wdata;
    logic [NP*MW-1:0]   port_byte_enable;
    logic [NP-1:0]      port_resp;
    logic [DW-1:0]      port_rdata;
    logic               mem_read, mem_write;
    logic [AW-1:0]      mem_address;
    logic [DW-1:0]      mem_wdata;
    logic [MW-1:0]      mem_byte_enable;
    logic               mem_resp;
    logic [DW-1:0]      mem_rdata;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .port_read(port_read), .port_write(port_write),
        .port_address(port_address), .port_wdata(port_wdata),
        .port_byte_enable(port_byte_enable),
        .port_resp(port_resp), .port_rdata(port_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one outstanding transaction plus the last winner.
    bit            m_busy;
    int            m_port;
    int            m_last;
    bit            m_rd, m_wr, m_granted;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_mask;

    // Environment controls
    bit            hold_rst, rand_mode, fixed_rdata;
    logic [NP-1:0] cont_ports;
    int            mem_delay, strobe_cnt, beef_seen;
    logic [NP-1:0] seen_resp;
    int            grant_log[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_port = 0; m_last = NP - 1; m_rd = 0; m_wr = 0;
        m_granted = 0; m_addr = '0; m_wdata = '0; m_mask = '0;
    endtask

    task automatic step();
        bit fire;
        bit found;
        int p;
        @(negedge clk);
        fire = m_busy && mem_resp && !rst;
        check_val("port_resp", port_resp, fire ? (64'd1 << m_port) : 64'd0);
        check_val("port_rdata", port_rdata, fire ? mem_rdata : '0);
        check_val("mem_read", mem_read, m_busy && m_rd);
        check_val("mem_write", mem_write, m_busy && m_wr);
        if (m_busy || !m_granted) begin
            check_val("mem_address", mem_address, m_addr);
            check_val("mem_wdata", mem_wdata, m_wdata);
            check_val("mem_byte_enable", mem_byte_enable, m_mask);
        end
        seen_resp = port_resp;
        for (int i = 0; i < NP; i++)
            if (port_resp[i]) grant_log.push_back(i);
        if (port_resp != 0 && port_rdata == 16'hBEEF) beef_seen++;

        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (!found && (port_read[p] || port_write[p])) begin
                    found     = 1;
                    m_busy    = 1;
                    m_port    = p;
                    m_last    = p;
                    m_granted = 1;
                    m_rd      = port_read[p];
                    m_wr      = !port_read[p];
                    m_addr    = port_address[p*AW +: AW];
                    m_wdata   = port_wdata[p*DW +: DW];
                    m_mask    = port_byte_enable[p*MW +: MW];
                end
            end
        end else if (mem_resp) begin
            m_busy = 0;
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (seen_resp[i] && !cont_ports[i]) begin
                port_read[i] = 1'b0;
                port_write[i] = 1'b0;
            end
            if (rand_mode) begin
                if (!port_read[i] && !port_write[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 3))
                            0, 3: begin port_read[i] = 1'b1; port_write[i] = 1'b0; end
                            1:    begin port_read[i] = 1'b0; port_write[i] = 1'b1; end
                            default: begin port_read[i] = 1'b1; port_write[i] = 1'b1; end
                        endcase
                        port_address[i*AW +: AW]   = AW'($urandom);
                        port_wdata[i*DW +: DW]     = DW'($urandom);
                        port_byte_enable[i*MW +: MW] = MW'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    port_read[i] = 1'b0;
                    port_write[i] = 1'b0;
                end
            end
        end
        if (mem_read || mem_write) begin
            if (strobe_cnt == 0 && rand_mode) mem_delay = $urandom_range(0, 3);
            strobe_cnt++;
            mem_resp  = (strobe_cnt > mem_delay);
            mem_rdata = (mem_resp && fixed_rdata) ? 16'hBEEF : DW'($urandom);
        end else begin
            strobe_cnt = 0;
            mem_resp   = rand_mode && ($urandom_range(0, 7) == 0);
            mem_rdata  = DW'($urandom);
        end
        rst = hold_rst || (rand_mode && $urandom_range(0, 79) == 0);
    endtask

    task automatic do_reset();
        port_read = '0; port_write = '0; cont_ports = '0;
        hold_rst = 1;
        rst = 1;
        repeat (2) step();
        hold_rst = 0;
        rst = 0;
        grant_log.delete();
        beef_seen = 0;
    endtask

    initial begin
        model_reset();
        rst = 1; hold_rst = 1; rand_mode = 0; fixed_rdata = 0; cont_ports = '0;
        port_read = '0; port_write = '0; port_address = '0; port_wdata = '0;
        port_byte_enable = '0; mem_resp = 0; mem_rdata = '0;
        mem_delay = 0; strobe_cnt = 0; beef_seen = 0; seen_resp = '0;

        // Single read on port 1, slow memory with fixed data
        do_reset();
        fixed_rdata = 1; mem_delay = 3;
        port_read[1] = 1'b1; port_address[1*AW +: AW] = 16'h1234;
        repeat (10) step();
        check_val("read_resp_count", grant_log.size(), 1);
        check_val("read_resp_port", log_at(0), 1);
        check_val("read_rdata_beef", beef_seen, 1);
        fixed_rdata = 0;

        // Write on port 0, then read+write collision on port 0
        do_reset();
        mem_delay = 1;
        port_write[0] = 1'b1; port_address[0 +: AW] = 16'h0040;
        port_wdata[0 +: DW] = 16'hA5A5; port_byte_enable[0 +: MW] = 2'b01;
        repeat (6) step();
        port_read[0] = 1'b1; port_write[0] = 1'b1; port_address[0 +: AW] = 16'h0ABC;
        repeat (6) step();
        check_val("wr_rw_resp_count", grant_log.size(), 2);

        // Contention between ports 0 and 1
        do_reset();
        mem_delay = 1; cont_ports = 4'b0011; port_read[0] = 1'b1; port_read[1] = 1'b1;
        repeat (13) step();
        check_val("rr01_g0", log_at(0), 0);
        check_val("rr01_g1", log_at(1), 1);
        check_val("rr01_g2", log_at(2), 0);
        check_val("rr01_g3", log_at(3), 1);

        // Ports 1 and 3 contending after reset
        do_reset();
        mem_delay = 1; cont_ports = 4'b1010; port_read[1] = 1'b1; port_read[3] = 1'b1;
        repeat (10) step();
        check_val("rr13_g0", log_at(0), 1);
        check_val("rr13_g1", log_at(1), 3);
        check_val("rr13_g2", log_at(2), 1);

        // Randomized traffic with spurious responses, drops and resets
        do_reset();
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        port_read = '0; port_write = '0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester channels (legal 2..8).
REQ-002 Parameter ADDR_WIDTH, default 16, address width in bits.
REQ-003 Parameter DATA_WIDTH, default 16, data width in bits (multiple of 8); MASK_WIDTH = DATA_WIDTH/8.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 port_read  input  NUM_PORTS  per-port read request.
REQ-007 port_write  input  NUM_PORTS  per-port write request.
REQ-008 port_address  input  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 port_wdata  input  NUM_PORTS*DATA_WIDTH  per-port write data, same slicing.
REQ-010 port_byte_enable  input  NUM_PORTS*MASK_WIDTH  per-port write byte mask, same slicing.
REQ-011 port_resp  output  NUM_PORTS  per-port completion pulse.
REQ-012 port_rdata  output  DATA_WIDTH  read data, shared by all ports.
REQ-013 mem_read  output  1  downstream read strobe.
REQ-014 mem_write  output  1  downstream write strobe.
REQ-015 mem_address  output  ADDR_WIDTH  downstream address.
REQ-016 mem_wdata  output  DATA_WIDTH  downstream write data.
REQ-017 mem_byte_enable  output  MASK_WIDTH  downstream byte mask.
REQ-018 mem_resp  input  1  downstream completion.
REQ-019 mem_rdata  input  DATA_WIDTH  downstream read data, valid when mem_resp=1.

Function
REQ-020 Requester protocol: port holds read or write, address, wdata, mask stable until it sees port_resp; downstream follows the same hold-until-mem_resp rule.
REQ-021 Two-state FSM: IDLE, BUSY.
REQ-022 IDLE: if any port_read|port_write bit is set, select winner by round-robin, latch its address, wdata, mask and op into registers, record grant index, go BUSY; else stay IDLE.
REQ-023 Round-robin: search starts at (last_grant+1) mod NUM_PORTS, increasing index with wrap; last_grant updates only on grant.
REQ-024 Port asserting both read and write: serviced as a read; write ignored for that transaction.
REQ-025 mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable are driven only from registers; asserted from the first cycle in BUSY, held constant through BUSY.
REQ-026 Latency: request sampled in IDLE at edge T yields mem_read or mem_write high in cycle T+1.
REQ-027 BUSY with mem_resp=1: port_resp[grant]=1 combinationally in the same cycle, port_rdata=mem_rdata; next state IDLE; mem_read/mem_write low from next cycle.
REQ-028 port_resp is one-hot or zero, never asserted outside a BUSY+mem_resp cycle; port_rdata is 0 when port_resp is all zero.
REQ-029 mem_resp while IDLE is ignored; no port_resp generated.
REQ-030 Requester dropping its request mid-BUSY: transaction still completes and port_resp still pulses.
REQ-031 One idle cycle between back-to-back transactions: mem_resp at cycle R, next strobe earliest at R+2.
REQ-032 New request arriving during BUSY waits; not lost if held per REQ-020.

Reset
REQ-033 rst=1 at an edge: state IDLE, last_grant=NUM_PORTS-1 (port 0 highest priority), all latched registers 0.
REQ-034 During and after reset until next grant: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, port_resp=0, port_rdata=0.
REQ-035 Reset in BUSY aborts the transaction: no port_resp issued, strobes low next cycle; rst has priority over mem_resp in the same cycle.

Verification
REQ-036 Single read: port1 read addr 0x1234, mem_resp 3 cycles after strobe with rdata 0xBEEF -> mem_read high T+1, mem_address 0x1234, port_resp=2'b10 with port_rdata 0xBEEF in resp cycle.
REQ-037 Write passthrough: port0 write addr 0x0040, wdata 0xA5A5, mask 2'b01 -> mem_write=1, mem_wdata 0xA5A5, mem_byte_enable 2'b01, port_resp=2'b01 on mem_resp.
REQ-038 Contention after reset: ports 0 and 1 both reading continuously, mem_resp 1 cycle after strobe -> grant order 0,1,0,1; strobe gap exactly one cycle.
REQ-039 NUM_PORTS=4, ports 1 and 3 requesting, last_grant=3 -> port 1 served, then 3, then 1.
REQ-040 Reset mid-BUSY: rst asserted same cycle as mem_resp -> port_resp stays 0, mem_read low next cycle, next grant goes to port 0 if requesting.
REQ-041 Read+write both set on port 0 -> only mem_read asserted, mem_write stays 0.
